fp16_div: RTL and testbench

FP16_DIV -- requirements
Module: fp16_div

---
 rtl/fp16_pkg.sv | 32 +++
 rtl/fp16_rne_round.sv | 46 ++++
 rtl/fp16_div.sv | 158 +++++++++++++++
 tb/tb_fp16_div.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the FP16 divider and multiplier.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package fp16_pkg;

  localparam int          BIAS    = 15;
  localparam logic [4:0]  EXP_INF = 5'h1F;
  localparam logic [15:0] QNAN    = 16'h7E00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_ROUND,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  function automatic logic [15:0] fp16_inf(input logic s);
    return {s, EXP_INF, 10'd0};
  endfunction

  function automatic logic [15:0] fp16_zero(input logic s);
    return {s, 15'd0};
  endfunction

endpackage

// File: rtl/fp16_rne_round.sv
// Normalise a 14-bit quotient/product significand and round to nearest, ties to even.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module fp16_rne_round
  import fp16_pkg::*;
(
  input  logic        i_sign,
  input  logic [6:0]  i_exp,
  input  logic [13:0] i_quot,
  input  logic        i_sticky,
  output logic [15:0] o_result
);

  logic              w_norm;
  logic signed [6:0] w_exp_n;
  logic signed [6:0] w_exp_f;
  logic [9:0]        w_mant;
  logic              w_g;
  logic              w_r;
  logic              w_s;
  logic              w_inc;
  logic              w_carry;
  logic [9:0]        w_frac;

  // Normalise (bit 13 is the leading one when set), round, then clamp the exponent range
  always_comb begin
    w_norm  = i_quot[13];
    w_exp_n = w_norm ? $signed(i_exp) : ($signed(i_exp) - 7'sd1);
    w_mant  = w_norm ? i_quot[12:3] : i_quot[11:2];
    w_g     = w_norm ? i_quot[2] : i_quot[1];
    w_r     = w_norm ? i_quot[1] : i_quot[0];
    w_s     = w_norm ? (i_quot[0] | i_sticky) : i_sticky;
    w_inc   = w_g & (w_r | w_s | w_mant[0]);
    // Hidden bit is always 1, so a carry out of the fraction means 10.000..; fraction wraps to 0
    {w_carry, w_frac} = {1'b0, w_mant} + {10'd0, w_inc};
    w_exp_f = w_exp_n + $signed({6'd0, w_carry});
    if (w_exp_f <= 7'sd0) begin
      o_result = fp16_zero(i_sign);
    end else if (w_exp_f >= 7'sd31) begin
      o_result = fp16_inf(i_sign);
    end else begin
      o_result = {i_sign, w_exp_f[4:0], w_frac};
    end
  end

endmodule

// File: rtl/fp16_div.sv
// Binary16 divider: restoring radix-2 significand division with RNE rounding, FTZ.
// Latency: fixed 17 cycles from capture edge to output_update, specials included.
// Backpressure: one request in flight; input_valid is ignored while busy (no queueing).
module fp16_div
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        input_valid,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [15:0] datanew,
  output logic        output_update,
  output logic        busy
);

  state_t      r_state;
  fp16_t       r_a;
  fp16_t       r_b;
  logic        r_sign;
  logic [6:0]  r_exp;
  logic [10:0] r_div;
  logic [11:0] r_rem;
  logic [13:0] r_quot;
  logic [3:0]  r_cnt;
  logic        r_special;
  logic [15:0] r_spec_val;
  logic [15:0] r_result;
  logic [15:0] r_datanew;
  logic        r_out_upd;
  logic        r_busy;

  logic        w_zero_a;
  logic        w_zero_b;
  logic        w_inf_a;
  logic        w_inf_b;
  logic        w_nan_a;
  logic        w_nan_b;
  logic        w_sign;
  logic [6:0]  w_exp;
  logic        w_special;
  logic [15:0] w_spec_val;
  logic [12:0] w_trial;
  logic        w_ge;
  logic [11:0] w_rem_keep;
  logic        w_sticky;
  logic [15:0] w_round;

  // Operand classification and exponent/sign for the LOAD cycle; subnormals count as zero
  always_comb begin
    w_zero_a   = (r_a.exp == 5'd0);
    w_zero_b   = (r_b.exp == 5'd0);
    w_inf_a    = (r_a.exp == EXP_INF) && (r_a.frac == 10'd0);
    w_inf_b    = (r_b.exp == EXP_INF) && (r_b.frac == 10'd0);
    w_nan_a    = (r_a.exp == EXP_INF) && (r_a.frac != 10'd0);
    w_nan_b    = (r_b.exp == EXP_INF) && (r_b.frac != 10'd0);
    w_sign     = r_a.sign ^ r_b.sign;
    w_exp      = {2'b00, r_a.exp} - {2'b00, r_b.exp} + 7'(BIAS);
    w_special  = 1'b1;
    w_spec_val = QNAN;
    if (w_nan_a || w_nan_b || (w_zero_a && w_zero_b) || (w_inf_a && w_inf_b)) begin
      w_spec_val = QNAN;
    end else if (w_inf_a || w_zero_b) begin
      w_spec_val = fp16_inf(w_sign);
    end else if (w_inf_b || w_zero_a) begin
      w_spec_val = fp16_zero(w_sign);
    end else begin
      w_special  = 1'b0;
      w_spec_val = 16'd0;
    end
  end

  // One restoring step: subtract the divisor if it fits, keep the partial remainder otherwise
  always_comb begin
    w_trial    = {1'b0, r_rem} - {2'b00, r_div};
    w_ge       = ~w_trial[12];
    w_rem_keep = w_ge ? w_trial[11:0] : r_rem;
    w_sticky   = |r_rem;
  end

  fp16_rne_round u_round (
    .i_sign   (r_sign),
    .i_exp    (r_exp),
    .i_quot   (r_quot),
    .i_sticky (w_sticky),
    .o_result (w_round)
  );

  // Control FSM and datapath registers; all outputs are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sign     <= 1'b0;
      r_exp      <= 7'd0;
      r_div      <= 11'd0;
      r_rem      <= 12'd0;
      r_quot     <= 14'd0;
      r_cnt      <= 4'd0;
      r_special  <= 1'b0;
      r_spec_val <= 16'd0;
      r_result   <= 16'd0;
      r_datanew  <= 16'd0;
      r_out_upd  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_out_upd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The cycle carrying output_update still reports busy, so nothing is taken then
          if (r_out_upd) begin
            r_busy <= 1'b0;
          end else if (input_valid && !r_busy) begin
            r_a     <= data1;
            r_b     <= data2;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_sign     <= w_sign;
          r_exp      <= w_exp;
          r_special  <= w_special;
          r_spec_val <= w_spec_val;
          r_div      <= {1'b1, r_b.frac};
          r_rem      <= {2'b01, r_a.frac};
          r_quot     <= 14'd0;
          r_cnt      <= 4'd0;
          r_state    <= ST_DIV;
        end
        ST_DIV: begin
          r_quot <= {r_quot[12:0], w_ge};
          r_rem  <= w_rem_keep << 1;
          r_cnt  <= r_cnt + 4'd1;
          if (r_cnt == 4'd13) begin
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_result <= r_special ? r_spec_val : w_round;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_datanew <= r_result;
          r_out_upd <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign datanew       = r_datanew;
  assign output_update = r_out_upd;
  assign busy          = r_busy;

endmodule

// File: tb/tb_fp16_div.sv
// Directed bench for fp16_div with a result/latency scoreboard.
// Latency: expects output_update 17 edges after capture.
// Backpressure: checks ignored requests while busy and during DONE.
module tb_fp16_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        input_valid;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [15:0] datanew;
  logic        output_update;
  logic        busy;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ncyc     = 0;
  int   n_upd    = 0;
  int   upd0;

  fp16_div dut (
    .clk           (clk),
    .rst           (rst),
    .input_valid   (input_valid),
    .data1         (data1),
    .data2         (data2),
    .datanew       (datanew),
    .output_update (output_update),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every output_update must match the oldest pending request in value and timing
  always @(negedge clk) begin
    ncyc++;
    if (output_update === 1'b1) begin
      n_upd++;
      if (sb.size() == 0) begin
        check("spurious_update", {31'd0, output_update}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", {16'd0, datanew}, {16'd0, mon_e.val});
        check("latency", ncyc, mon_e.due);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ev);
    exp_t e;
    @(posedge clk); #1;
    data1       = a;
    data2       = b;
    input_valid = 1'b1;
    e.val       = ev;
    e.due       = ncyc + 19;
    sb.push_back(e);
    @(posedge clk); #1;
    input_valid = 1'b0;
    check("busy_after_capture", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    check("drain", sb.size(), 32'd0);
    @(posedge clk); #1;
    check("busy_release", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    input_valid = 1'b0;
    data1       = 16'h0000;
    data2       = 16'h0000;
    repeat (2) @(posedge clk); #1;
    check("reset_datanew", {16'd0, datanew}, 32'h0);
    check("reset_update", {31'd0, output_update}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Basic quotients, RNE, specials and exponent boundaries
    send(16'h4600, 16'h4000, 16'h4200); wait_done();
    repeat (3) @(posedge clk); #1;
    check("hold_datanew", {16'd0, datanew}, 32'h4200);
    send(16'h3C00, 16'h4200, 16'h3555); wait_done();
    send(16'h4500, 16'h4200, 16'h3EAB); wait_done();
    send(16'hBC00, 16'h4200, 16'hB555); wait_done();
    send(16'h4200, 16'h4200, 16'h3C00); wait_done();
    send(16'h3C00, 16'h0000, 16'h7C00); wait_done();
    send(16'h3C00, 16'h8000, 16'hFC00); wait_done();
    send(16'h0000, 16'h0000, 16'h7E00); wait_done();
    send(16'hFC00, 16'h4000, 16'hFC00); wait_done();
    send(16'h7E01, 16'h3C00, 16'h7E00); wait_done();
    send(16'h7C00, 16'h7C00, 16'h7E00); wait_done();
    send(16'h4000, 16'h7C00, 16'h0000); wait_done();
    send(16'h8000, 16'h4000, 16'h8000); wait_done();
    send(16'h0001, 16'h3C00, 16'h0000); wait_done();
    send(16'h7BFF, 16'h3800, 16'h7C00); wait_done();
    send(16'h7BFF, 16'h3C00, 16'h7BFF); wait_done();
    send(16'h0400, 16'h7BFF, 16'h0000); wait_done();
    send(16'h0400, 16'h3C00, 16'h0400); wait_done();
    send(16'h0400, 16'h4000, 16'h0000); wait_done();

    // Requests while busy and in the DONE cycle are dropped
    @(posedge clk); #1;
    data1       = 16'h4600;
    data2       = 16'h4000;
    input_valid = 1'b1;
    sb.push_back('{val: 16'h4200, due: ncyc + 19});
    @(posedge clk); #1;
    input_valid = 1'b0;
    upd0 = n_upd;
    repeat (4) @(posedge clk); #1;
    data1       = 16'h3C00;
    data2       = 16'h4200;
    input_valid = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    repeat (11) @(posedge clk); #1;
    input_valid = 1'b1;
    repeat (2) @(posedge clk); #1;
    input_valid = 1'b0;
    repeat (25) @(posedge clk); #1;
    check("single_update", n_upd - upd0, 32'd1);
    check("no_queued_result", sb.size(), 32'd0);
    check("idle_after_ignored", {31'd0, busy}, 32'd0);

    // Reset in the middle of DIV aborts silently
    @(posedge clk); #1;
    data1       = 16'h4600;
    data2       = 16'h4000;
    input_valid = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    upd0 = n_upd;
    repeat (9) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_datanew", {16'd0, datanew}, 32'h0);
    check("abort_update", {31'd0, output_update}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (25) @(posedge clk); #1;
    check("abort_no_update", n_upd - upd0, 32'd0);
    check("abort_datanew_after", {16'd0, datanew}, 32'h0);
    check("abort_busy_after", {31'd0, busy}, 32'd0);
    send(16'h4440, 16'h4000, 16'h4040); wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
